// File: rtl/flash_read_buffer_pkg.sv
// Shared types and default geometry for the flash read line buffer.
package flash_read_buffer_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 21;
   localparam int unsigned DEF_LINE_WORDS = 4;
   localparam int unsigned DEF_NUM_LINES  = 4;

   localparam int unsigned OFFSET_W = $clog2(DEF_LINE_WORDS);
   localparam int unsigned INDEX_W  = $clog2(DEF_NUM_LINES);
   localparam int unsigned TAG_W    = DEF_ADDR_WIDTH - OFFSET_W - INDEX_W;

   typedef logic [DEF_ADDR_WIDTH-1:0] FlashWordAddress_t;

   typedef enum logic [2:0] {
      IDLE,
      FILL_REQ,
      FILL_WAIT,
      WR_REQ,
      WR_WAIT,
      DONE
   } line_state_e;

endpackage

// File: rtl/flash_read_buffer_line_store.sv
// flash_line_store: valid/tag/data arrays with combinational hit lookup,
// one word write port, per-line set/clear of valid and invalidate-all.
module flash_line_store
   import flash_read_buffer_pkg::*;
#(
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
   parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
   parameter int unsigned OFF_W      = OFFSET_W,
   parameter int unsigned IDX_W      = INDEX_W,
   parameter int unsigned TAG_BITS   = TAG_W
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [IDX_W-1:0]    i_lk_index,
   input  logic [TAG_BITS-1:0] i_lk_tag,
   input  logic [OFF_W-1:0]    i_lk_offset,
   output logic                o_hit,
   output logic [31:0]         o_word,
   input  logic                i_wr_en,
   input  logic [IDX_W-1:0]    i_wr_index,
   input  logic [OFF_W-1:0]    i_wr_offset,
   input  logic [31:0]         i_wr_data,
   input  logic                i_set_valid,
   input  logic [TAG_BITS-1:0] i_set_tag,
   input  logic                i_clr_en,
   input  logic [IDX_W-1:0]    i_clr_index,
   input  logic                i_inv_all
);

   logic [NUM_LINES-1:0] r_valid;
   logic [TAG_BITS-1:0]  r_tag  [NUM_LINES];
   logic [31:0]          r_data [NUM_LINES][LINE_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_rst || i_inv_all) begin
         r_valid <= '0;
      end else begin
         if (i_clr_en)    r_valid[i_clr_index] <= 1'b0;
         if (i_set_valid) r_valid[i_wr_index]  <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_set_valid) r_tag[i_wr_index] <= i_set_tag;
      if (i_wr_en)     r_data[i_wr_index][i_wr_offset] <= i_wr_data;
   end

   assign o_hit  = r_valid[i_lk_index] && (r_tag[i_lk_index] == i_lk_tag);
   assign o_word = r_data[i_lk_index][i_lk_offset];

endmodule

// File: rtl/flash_read_buffer.sv
// flash_read_buffer: direct-mapped read line buffer between CPU bus and flash controller.
// Optional hit/miss counters are enabled by defining FLASH_READ_BUFFER_STATS_EN.
module flash_read_buffer
   import flash_read_buffer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
   parameter int unsigned NUM_LINES  = DEF_NUM_LINES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic [ADDR_WIDTH-1:0] cpu_address,
   input  logic [3:0]            cpu_mask,
   input  logic [31:0]           cpu_data_wr,
   output logic [31:0]           cpu_data_rd,
   output logic                  cpu_stall,
   output logic                  fl_read,
   output logic                  fl_write,
   output logic [ADDR_WIDTH-1:0] fl_address,
   output logic [3:0]            fl_mask,
   output logic [31:0]           fl_data_wr,
   input  logic [31:0]           fl_data_rd,
   input  logic                  fl_stall
`ifdef FLASH_READ_BUFFER_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int unsigned OFF_W    = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W    = $clog2(NUM_LINES);
   localparam int unsigned TAG_BITS = ADDR_WIDTH - OFF_W - IDX_W;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   line_state_e r_state, w_state_nxt;

   logic [OFF_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_index;
   logic [TAG_BITS-1:0]   r_tag;
   logic                  r_seen;
   logic                  r_fl_read, r_fl_write;
   logic [ADDR_WIDTH-1:0] r_fl_address;
   logic [3:0]            r_fl_mask;
   logic [31:0]           r_fl_data_wr;

   logic [OFF_W-1:0]    w_offset;
   logic [IDX_W-1:0]    w_index;
   logic [TAG_BITS-1:0] w_tag;
   logic                w_hit, w_hit_idle, w_miss, w_wr_start;
   logic                w_xfer_done, w_store, w_set_valid, w_inv_all;
   logic [31:0]         w_word;

   assign w_offset = cpu_address[OFF_W-1:0];
   assign w_index  = cpu_address[OFF_W +: IDX_W];
   assign w_tag    = cpu_address[ADDR_WIDTH-1 -: TAG_BITS];

   assign w_hit_idle  = (r_state == IDLE) && cpu_read && w_hit;
   assign w_miss      = (r_state == IDLE) && cpu_read && !w_hit;
   assign w_wr_start  = (r_state == IDLE) && cpu_write && !cpu_read;
   // A transfer completes in the first low-stall cycle after stall was seen high.
   assign w_xfer_done = r_seen && !fl_stall;
   assign w_store     = (r_state == FILL_WAIT) && w_xfer_done;
   assign w_set_valid = w_store && (r_cnt == LAST_WORD);
   assign w_inv_all   = (r_state == WR_WAIT) && w_xfer_done;

   flash_line_store #(
      .LINE_WORDS (LINE_WORDS),
      .NUM_LINES  (NUM_LINES),
      .OFF_W      (OFF_W),
      .IDX_W      (IDX_W),
      .TAG_BITS   (TAG_BITS)
   ) u_store (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_lk_index  (w_index),
      .i_lk_tag    (w_tag),
      .i_lk_offset (w_offset),
      .o_hit       (w_hit),
      .o_word      (w_word),
      .i_wr_en     (w_store),
      .i_wr_index  (r_index),
      .i_wr_offset (r_cnt),
      .i_wr_data   (fl_data_rd),
      .i_set_valid (w_set_valid),
      .i_set_tag   (r_tag),
      .i_clr_en    (w_miss),
      .i_clr_index (w_index),
      .i_inv_all   (w_inv_all)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_miss)          w_state_nxt = FILL_REQ;
            else if (w_wr_start) w_state_nxt = WR_REQ;
         end
         FILL_REQ:  w_state_nxt = FILL_WAIT;
         FILL_WAIT: if (w_xfer_done) w_state_nxt = (r_cnt == LAST_WORD) ? DONE : FILL_REQ;
         WR_REQ:    w_state_nxt = WR_WAIT;
         WR_WAIT:   if (w_xfer_done) w_state_nxt = DONE;
         DONE:      w_state_nxt = IDLE;
         default:   w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt        <= '0;
         r_index      <= '0;
         r_tag        <= '0;
         r_seen       <= 1'b0;
         r_fl_read    <= 1'b0;
         r_fl_write   <= 1'b0;
         r_fl_address <= '0;
         r_fl_mask    <= '0;
         r_fl_data_wr <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (w_miss) begin
                  r_cnt   <= '0;
                  r_index <= w_index;
                  r_tag   <= w_tag;
               end else if (w_wr_start) begin
                  r_fl_address <= cpu_address;
                  r_fl_mask    <= cpu_mask;
                  r_fl_data_wr <= cpu_data_wr;
               end
            end
            FILL_REQ: begin
               r_fl_read    <= 1'b1;
               r_fl_address <= {r_tag, r_index, r_cnt};
               r_seen       <= 1'b0;
            end
            FILL_WAIT: begin
               if (fl_stall) r_seen <= 1'b1;
               if (w_xfer_done) begin
                  r_fl_read <= 1'b0;
                  if (r_cnt != LAST_WORD) r_cnt <= r_cnt + 1'b1;
               end
            end
            WR_REQ: begin
               r_fl_write <= 1'b1;
               r_seen     <= 1'b0;
            end
            WR_WAIT: begin
               if (fl_stall)    r_seen     <= 1'b1;
               if (w_xfer_done) r_fl_write <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef FLASH_READ_BUFFER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (w_hit_idle) hit_count  <= hit_count + 1'b1;
         if (w_miss)     miss_count <= miss_count + 1'b1;
      end
   end
`endif

   assign cpu_stall   = (cpu_read || cpu_write) && (r_state != DONE) && !w_hit_idle;
   assign cpu_data_rd = (cpu_read && w_hit && (r_state == IDLE || r_state == DONE)) ? w_word : '0;

   assign fl_read    = r_fl_read;
   assign fl_write   = r_fl_write;
   assign fl_address = r_fl_address;
   assign fl_mask    = r_fl_mask;
   assign fl_data_wr = r_fl_data_wr;

endmodule

// File: tb/tb_flash_read_buffer.sv
// Directed bench for flash_read_buffer with a behavioural flash controller
// (3 stall cycles per transfer, so 5 request-high cycles and 26-cycle read misses).
module tb_flash_read_buffer;
   import flash_read_buffer_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_read, cpu_write;
   FlashWordAddress_t cpu_address;
   logic [3:0]        cpu_mask;
   logic [31:0]       cpu_data_wr, cpu_data_rd;
   logic              cpu_stall;
   logic              fl_read, fl_write;
   FlashWordAddress_t fl_address;
   logic [3:0]        fl_mask;
   logic [31:0]       fl_data_wr;
   logic [31:0]       fl_data_rd;
   logic              fl_stall;
`ifdef FLASH_READ_BUFFER_STATS_EN
   logic [31:0]       hit_count, miss_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   flash_read_buffer #(
      .ADDR_WIDTH (21),
      .LINE_WORDS (4),
      .NUM_LINES  (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_read    (cpu_read),
      .cpu_write   (cpu_write),
      .cpu_address (cpu_address),
      .cpu_mask    (cpu_mask),
      .cpu_data_wr (cpu_data_wr),
      .cpu_data_rd (cpu_data_rd),
      .cpu_stall   (cpu_stall),
      .fl_read     (fl_read),
      .fl_write    (fl_write),
      .fl_address  (fl_address),
      .fl_mask     (fl_mask),
      .fl_data_wr  (fl_data_wr),
      .fl_data_rd  (fl_data_rd),
      .fl_stall    (fl_stall)
`ifdef FLASH_READ_BUFFER_STATS_EN
      ,
      .hit_count   (hit_count),
      .miss_count  (miss_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] flash_word(input FlashWordAddress_t a);
      return {11'h5A5, a};
   endfunction

   // Controller model: accept, stall 3 cycles, complete, then wait for request low.
   int                c_state;
   int                c_cnt;
   FlashWordAddress_t c_addr;
   FlashWordAddress_t rd_log[$];
   int                wr_cnt;
   FlashWordAddress_t wr_addr;
   logic [3:0]        wr_mask;
   logic [31:0]       wr_data;

   always @(posedge clk) begin
      if (rst) begin
         c_state    <= 0;
         c_cnt      <= 0;
         fl_stall   <= 1'b0;
         fl_data_rd <= '0;
      end else begin
         case (c_state)
            0: if (fl_read || fl_write) begin
                  c_addr   <= fl_address;
                  c_cnt    <= 3;
                  fl_stall <= 1'b1;
                  c_state  <= 1;
                  if (fl_read) rd_log.push_back(fl_address);
                  else begin
                     wr_cnt  <= wr_cnt + 1;
                     wr_addr <= fl_address;
                     wr_mask <= fl_mask;
                     wr_data <= fl_data_wr;
                  end
               end
            1: if (c_cnt == 1) begin
                  fl_stall   <= 1'b0;
                  fl_data_rd <= flash_word(c_addr);
                  c_state    <= 2;
               end else c_cnt <= c_cnt - 1;
            default: if (!fl_read && !fl_write) c_state <= 0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cpu_rd(input FlashWordAddress_t a, output logic [31:0] d, output int cyc);
      bit ok;
      ok = 1'b0;
      d = '0;
      cyc = 0;
      @(posedge clk); #1;
      cpu_address = a;
      cpu_read = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cyc++;
         if (!cpu_stall) begin
            d = cpu_data_rd;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("rd_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      cpu_read = 1'b0;
   endtask

   task automatic cpu_wr(input FlashWordAddress_t a, input logic [3:0] m,
                         input logic [31:0] d, output int cyc);
      bit ok;
      ok = 1'b0;
      cyc = 0;
      @(posedge clk); #1;
      cpu_address = a;
      cpu_mask = m;
      cpu_data_wr = d;
      cpu_write = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         cyc++;
         if (!cpu_stall) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wr_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      cpu_write = 1'b0;
   endtask

   task automatic check_fill(input string tag, input int base, input FlashWordAddress_t line);
      FlashWordAddress_t got;
      check({tag, "_nreads"}, 64'(rd_log.size()), 64'(base + 4));
      for (int k = 0; k < 4; k++) begin
         got = (base + k < rd_log.size()) ? rd_log[base + k] : '1;
         check($sformatf("%s_addr%0d", tag, k), 64'(got), 64'(line + FlashWordAddress_t'(k)));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] d;
      int          cyc, base, wbase;
      bit          ok;

      rst = 1'b1;
      cpu_read = 1'b0;
      cpu_write = 1'b0;
      cpu_address = '0;
      cpu_mask = '0;
      cpu_data_wr = '0;
      wr_cnt = 0;
      wr_addr = '0;
      wr_mask = '0;
      wr_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst_fl_read",  64'(fl_read), 64'd0);
      check("rst_fl_write", 64'(fl_write), 64'd0);
      check("rst_fl_addr",  64'(fl_address), 64'd0);
      check("rst_fl_mask",  64'(fl_mask), 64'd0);
      check("rst_fl_wdata", 64'(fl_data_wr), 64'd0);
      check("rst_cpu_rd",   64'(cpu_data_rd), 64'd0);
      check("rst_stall",    64'(cpu_stall), 64'd0);

      // Cold miss, requested offset 1 of line 0x4
      base = rd_log.size();
      cpu_rd(21'h000005, d, cyc);
      check("cold_data", 64'(d), 64'(flash_word(21'h000005)));
      check("cold_latency", 64'(cyc), 64'd26);
      check_fill("cold", base, 21'h000004);

      // Hit, zero latency
      base = rd_log.size();
      cpu_rd(21'h000006, d, cyc);
      check("hit_data", 64'(d), 64'(flash_word(21'h000006)));
      check("hit_latency", 64'(cyc), 64'd1);
      check("hit_no_fl_read", 64'(rd_log.size()), 64'(base));

      // Conflict miss on same index
      base = rd_log.size();
      cpu_rd(21'h000015, d, cyc);
      check("conf_data", 64'(d), 64'(flash_word(21'h000015)));
      check("conf_latency", 64'(cyc), 64'd26);
      check_fill("conf", base, 21'h000014);

`ifdef FLASH_READ_BUFFER_STATS_EN
      check("stats_hit",  64'(hit_count), 64'd1);
      check("stats_miss", 64'(miss_count), 64'd2);
`endif

      base = rd_log.size();
      cpu_rd(21'h000005, d, cyc);
      check("evicted_latency", 64'(cyc), 64'd26);
      check_fill("evicted", base, 21'h000004);

      // Write passes through and invalidates every line
      base = rd_log.size();
      wbase = wr_cnt;
      cpu_wr(21'h000006, 4'b0011, 32'h1234_5678, cyc);
      check("wr_latency", 64'(cyc), 64'd8);
      check("wr_count", 64'(wr_cnt - wbase), 64'd1);
      check("wr_addr", 64'(wr_addr), 64'h6);
      check("wr_mask", 64'(wr_mask), 64'h3);
      check("wr_data", 64'(wr_data), 64'h1234_5678);
      check("wr_no_fl_read", 64'(rd_log.size()), 64'(base));

      base = rd_log.size();
      cpu_rd(21'h000006, d, cyc);
      check("post_wr_data", 64'(d), 64'(flash_word(21'h000006)));
      check("post_wr_latency", 64'(cyc), 64'd26);
      check_fill("post_wr", base, 21'h000004);

      // Top of the address space
      base = rd_log.size();
      cpu_rd(21'h1FFFFE, d, cyc);
      check("top_data", 64'(d), 64'(flash_word(21'h1FFFFE)));
      check_fill("top", base, 21'h1FFFFC);

      // Reset during the second word of a fill
      @(posedge clk); #1;
      base = rd_log.size();
      cpu_address = 21'h000025;
      cpu_read = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (rd_log.size() >= base + 2) begin
            ok = 1'b1;
            break;
         end
      end
      check("midfill_reached", 64'(ok), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      cpu_read = 1'b0;
      @(posedge clk); #1;
      check("midfill_fl_read", 64'(fl_read), 64'd0);
      check("midfill_fl_addr", 64'(fl_address), 64'd0);
      rst = 1'b0;

      base = rd_log.size();
      cpu_rd(21'h000025, d, cyc);
      check("refill_data", 64'(d), 64'(flash_word(21'h000025)));
      check("refill_latency", 64'(cyc), 64'd26);
      check_fill("refill", base, 21'h000024);

      base = rd_log.size();
      cpu_rd(21'h000027, d, cyc);
      check("refill_hit_data", 64'(d), 64'(flash_word(21'h000027)));
      check("refill_hit_latency", 64'(cyc), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
